// File: rtl/dsp48a1_slice_pkg.sv
// ============================================================================
// Module : dsp48a1_slice_pkg
// Brief  : OPMODE bit positions and X/Z mux select encodings for the slice.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package dsp48a1_slice_pkg;

  localparam int OPM_PREUSE  = 4;
  localparam int OPM_CIN     = 5;
  localparam int OPM_PRESUB  = 6;
  localparam int OPM_POSTSUB = 7;

  typedef enum logic [1:0] {
    X_ZERO = 2'd0,
    X_M    = 2'd1,
    X_P    = 2'd2,
    X_DAB  = 2'd3
  } xsel_e;

  typedef enum logic [1:0] {
    Z_ZERO = 2'd0,
    Z_PCIN = 2'd1,
    Z_P    = 2'd2,
    Z_C    = 2'd3
  } zsel_e;

endpackage

`default_nettype wire

// File: rtl/dsp_pipe_reg.sv
// ============================================================================
// Module : dsp_pipe_reg
// Brief  : One optional pipeline stage with clock enable and async reset.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module dsp_pipe_reg #(
  parameter int WIDTH = 18,
  parameter int REG   = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ce_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  generate
    if (REG == 1) begin : g_reg
      logic [WIDTH-1:0] data_q;
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)     data_q <= '0;
        else if (ce_i) data_q <= d_i;
      end
      assign q_o = data_q;
    end else begin : g_bypass
      // Control pins are intentionally dead when the stage is a wire.
      logic unused_ctrl;
      assign unused_ctrl = clk_i ^ rst_i ^ ce_i;
      assign q_o = d_i;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/dsp48a1_slice.sv
// ============================================================================
// Module : dsp48a1_slice
// Brief  : DSP48A1-style slice: pre-adder, 18x18 multiplier, 48-bit post-adder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module dsp48a1_slice
  import dsp48a1_slice_pkg::*;
#(
  parameter int    A0REG       = 0,
  parameter int    A1REG       = 1,
  parameter int    B0REG       = 0,
  parameter int    B1REG       = 1,
  parameter int    CREG        = 1,
  parameter int    DREG        = 1,
  parameter int    MREG        = 1,
  parameter int    PREG        = 1,
  parameter int    CARRYINREG  = 1,
  parameter int    CARRYOUTREG = 1,
  parameter int    OPMODEREG   = 1,
  parameter string CARRYINSEL  = "OPMODE5",
  parameter string B_INPUT     = "DIRECT"
) (
  input  logic        CLK,
  input  logic        RSTA,
  input  logic        RSTB,
  input  logic        RSTC,
  input  logic        RSTD,
  input  logic        RSTM,
  input  logic        RSTP,
  input  logic        RSTCARRYIN,
  input  logic        RSTOPMODE,
  input  logic [17:0] A,
  input  logic [17:0] B,
  input  logic [17:0] D,
  input  logic [17:0] BCIN,
  input  logic [47:0] C,
  input  logic [47:0] PCIN,
  input  logic        CARRYIN,
  input  logic [7:0]  OPMODE,
  input  logic        CEA,
  input  logic        CEB,
  input  logic        CEC,
  input  logic        CED,
  input  logic        CEM,
  input  logic        CEP,
  input  logic        CECARRYIN,
  input  logic        CEOPMODE,
  output logic [35:0] M,
  output logic [47:0] P,
  output logic [47:0] PCOUT,
  output logic [17:0] BCOUT,
  output logic        CARRYOUT,
  output logic        CARRYOUTF
);

  logic [7:0]  opm_q;
  logic [17:0] d_q, a0_q, a1_q, b0_d, b0_q, b1_d, b1_q, preadd;
  logic [35:0] m_d, m_q;
  logic [47:0] c_q, x_mux, z_mux, p_q;
  logic [48:0] post_d;
  logic        cin_d, cin_q, co_q;

  dsp_pipe_reg #(.WIDTH(8), .REG(OPMODEREG)) u_opm (
    .clk_i(CLK), .rst_i(RSTOPMODE), .ce_i(CEOPMODE), .d_i(OPMODE), .q_o(opm_q));

  dsp_pipe_reg #(.WIDTH(18), .REG(DREG)) u_d (
    .clk_i(CLK), .rst_i(RSTD), .ce_i(CED), .d_i(D), .q_o(d_q));

  dsp_pipe_reg #(.WIDTH(48), .REG(CREG)) u_c (
    .clk_i(CLK), .rst_i(RSTC), .ce_i(CEC), .d_i(C), .q_o(c_q));

  dsp_pipe_reg #(.WIDTH(18), .REG(A0REG)) u_a0 (
    .clk_i(CLK), .rst_i(RSTA), .ce_i(CEA), .d_i(A), .q_o(a0_q));

  dsp_pipe_reg #(.WIDTH(18), .REG(A1REG)) u_a1 (
    .clk_i(CLK), .rst_i(RSTA), .ce_i(CEA), .d_i(a0_q), .q_o(a1_q));

  generate
    if (B_INPUT == "CASCADE") begin : g_b_cascade
      logic unused_b;
      assign unused_b = ^B;
      assign b0_d = BCIN;
    end else if (B_INPUT == "DIRECT") begin : g_b_direct
      logic unused_bcin;
      assign unused_bcin = ^BCIN;
      assign b0_d = B;
    end else begin : g_b_invalid
      logic unused_bsrc;
      assign unused_bsrc = ^{B, BCIN};
      assign b0_d = '0;
    end
  endgenerate

  dsp_pipe_reg #(.WIDTH(18), .REG(B0REG)) u_b0 (
    .clk_i(CLK), .rst_i(RSTB), .ce_i(CEB), .d_i(b0_d), .q_o(b0_q));

  assign preadd = opm_q[OPM_PRESUB] ? (d_q - b0_q) : (d_q + b0_q);
  assign b1_d   = opm_q[OPM_PREUSE] ? preadd : b0_q;

  dsp_pipe_reg #(.WIDTH(18), .REG(B1REG)) u_b1 (
    .clk_i(CLK), .rst_i(RSTB), .ce_i(CEB), .d_i(b1_d), .q_o(b1_q));

  assign m_d = 36'(a1_q) * 36'(b1_q);

  dsp_pipe_reg #(.WIDTH(36), .REG(MREG)) u_m (
    .clk_i(CLK), .rst_i(RSTM), .ce_i(CEM), .d_i(m_d), .q_o(m_q));

  generate
    if (CARRYINSEL == "OPMODE5") begin : g_cin_opmode
      logic unused_carryin;
      assign unused_carryin = CARRYIN;
      assign cin_d = opm_q[OPM_CIN];
    end else if (CARRYINSEL == "CARRYIN") begin : g_cin_port
      assign cin_d = CARRYIN;
    end else begin : g_cin_invalid
      logic unused_carryin;
      assign unused_carryin = CARRYIN;
      assign cin_d = 1'b0;
    end
  endgenerate

  dsp_pipe_reg #(.WIDTH(1), .REG(CARRYINREG)) u_cin (
    .clk_i(CLK), .rst_i(RSTCARRYIN), .ce_i(CECARRYIN), .d_i(cin_d), .q_o(cin_q));

  always_comb begin
    x_mux = '0;
    case (xsel_e'(opm_q[1:0]))
      X_ZERO:  x_mux = '0;
      X_M:     x_mux = {12'd0, m_q};
      X_P:     x_mux = p_q;
      X_DAB:   x_mux = {d_q[11:0], a1_q, b1_q};
      default: x_mux = '0;
    endcase
  end

  always_comb begin
    z_mux = '0;
    case (zsel_e'(opm_q[3:2]))
      Z_ZERO:  z_mux = '0;
      Z_PCIN:  z_mux = PCIN;
      Z_P:     z_mux = p_q;
      Z_C:     z_mux = c_q;
      default: z_mux = '0;
    endcase
  end

  // Bit 48 is the carry on add and the borrow on subtract.
  assign post_d = opm_q[OPM_POSTSUB] ? ({1'b0, z_mux} - ({1'b0, x_mux} + 49'(cin_q)))
                                     : ({1'b0, z_mux} + {1'b0, x_mux} + 49'(cin_q));

  dsp_pipe_reg #(.WIDTH(48), .REG(PREG)) u_p (
    .clk_i(CLK), .rst_i(RSTP), .ce_i(CEP), .d_i(post_d[47:0]), .q_o(p_q));

  dsp_pipe_reg #(.WIDTH(1), .REG(CARRYOUTREG)) u_co (
    .clk_i(CLK), .rst_i(RSTP), .ce_i(CEP), .d_i(post_d[48]), .q_o(co_q));

  assign M         = m_q;
  assign P         = p_q;
  assign PCOUT     = p_q;
  assign BCOUT     = b1_q;
  assign CARRYOUT  = co_q;
  assign CARRYOUTF = co_q;

endmodule

`default_nettype wire

// File: tb/tb_dsp48a1_slice.sv
// ============================================================================
// Module : tb_dsp48a1_slice
// Brief  : Self-checking bench for dsp48a1_slice (fully registered build).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dsp48a1_slice;

  logic        CLK = 1'b0;
  logic        rst;
  logic        cep;
  logic [17:0] A, B, D, BCIN;
  logic [47:0] C, PCIN;
  logic [7:0]  OPMODE;
  logic        CARRYIN;
  logic [35:0] M, k_M;
  logic [47:0] P, PCOUT, k_P, k_PCOUT;
  logic [17:0] BCOUT, k_BCOUT;
  logic        CARRYOUT, CARRYOUTF, k_CARRYOUT, k_CARRYOUTF;

  int n_chk  = 0;
  int n_pass = 0;
  logic chk_en = 1'b0;

  always #5 CLK = ~CLK;

  dsp48a1_slice #(
    .A0REG(1), .A1REG(1), .B0REG(1), .B1REG(1), .CREG(1), .DREG(1), .MREG(1),
    .PREG(1), .CARRYINREG(1), .CARRYOUTREG(1), .OPMODEREG(1),
    .CARRYINSEL("OPMODE5"), .B_INPUT("DIRECT")
  ) dut (
    .CLK(CLK), .RSTA(rst), .RSTB(rst), .RSTC(rst), .RSTD(rst), .RSTM(rst),
    .RSTP(rst), .RSTCARRYIN(rst), .RSTOPMODE(rst),
    .A(A), .B(B), .D(D), .BCIN(BCIN), .C(C), .PCIN(PCIN), .CARRYIN(CARRYIN),
    .OPMODE(OPMODE), .CEA(1'b1), .CEB(1'b1), .CEC(1'b1), .CED(1'b1), .CEM(1'b1),
    .CEP(cep), .CECARRYIN(1'b1), .CEOPMODE(1'b1),
    .M(M), .P(P), .PCOUT(PCOUT), .BCOUT(BCOUT), .CARRYOUT(CARRYOUT),
    .CARRYOUTF(CARRYOUTF)
  );

  dsp48a1_slice #(
    .A0REG(1), .A1REG(1), .B0REG(1), .B1REG(1), .CREG(1), .DREG(1), .MREG(1),
    .PREG(1), .CARRYINREG(1), .CARRYOUTREG(1), .OPMODEREG(1),
    .CARRYINSEL("OPMODE5"), .B_INPUT("CASCADE")
  ) dut_cas (
    .CLK(CLK), .RSTA(rst), .RSTB(rst), .RSTC(rst), .RSTD(rst), .RSTM(rst),
    .RSTP(rst), .RSTCARRYIN(rst), .RSTOPMODE(rst),
    .A(A), .B(B), .D(D), .BCIN(BCIN), .C(C), .PCIN(PCIN), .CARRYIN(CARRYIN),
    .OPMODE(OPMODE), .CEA(1'b1), .CEB(1'b1), .CEC(1'b1), .CED(1'b1), .CEM(1'b1),
    .CEP(cep), .CECARRYIN(1'b1), .CEOPMODE(1'b1),
    .M(k_M), .P(k_P), .PCOUT(k_PCOUT), .BCOUT(k_BCOUT), .CARRYOUT(k_CARRYOUT),
    .CARRYOUTF(k_CARRYOUTF)
  );

  // ---------------- latency-based reference model ----------------
  // h0 = inputs seen at the previous edge, h1 = the edge before that.
  typedef struct packed {
    logic [7:0]  opm;
    logic [17:0] a, b, d;
    logic [47:0] c, pcin;
    logic        cep;
  } smp_t;

  smp_t        cur_s, h0, h1;
  logic [17:0] exp_bc;
  logic [35:0] exp_m;
  logic [47:0] exp_p;
  logic        exp_co, exp_cin;

  assign cur_s = {OPMODE, A, B, D, C, PCIN, cep};

  function automatic logic [17:0] pre_f(smp_t s);
    logic [17:0] r;
    if (!s.opm[4])     r = s.b;
    else if (s.opm[6]) r = s.d - s.b;
    else               r = s.d + s.b;
    return r;
  endfunction

  function automatic logic [47:0] x_f(logic [1:0] sel, logic [35:0] m, logic [47:0] p,
                                      logic [17:0] d, logic [17:0] a, logic [17:0] b);
    logic [47:0] r;
    case (sel)
      2'd1:    r = {12'd0, m};
      2'd2:    r = p;
      2'd3:    r = {d[11:0], a, b};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [47:0] z_f(logic [1:0] sel, logic [47:0] pcin, logic [47:0] p,
                                      logic [47:0] c);
    logic [47:0] r;
    case (sel)
      2'd1:    r = pcin;
      2'd2:    r = p;
      2'd3:    r = c;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [48:0] post_f(logic sub, logic [47:0] xv, logic [47:0] zv, logic ci);
    logic [48:0] r;
    if (sub) r = {1'b0, zv} - {1'b0, xv} - {48'd0, ci};
    else     r = {1'b0, zv} + {1'b0, xv} + {48'd0, ci};
    return r;
  endfunction

  always @(posedge CLK or posedge rst) begin
    if (rst) begin
      h0 <= '0; h1 <= '0;
      exp_bc <= '0; exp_m <= '0; exp_p <= '0; exp_co <= 1'b0; exp_cin <= 1'b0;
    end else begin
      exp_bc  <= pre_f(h0);
      exp_m   <= 36'(h1.a) * 36'(exp_bc);
      exp_cin <= h0.opm[5];
      if (cur_s.cep)
        {exp_co, exp_p} <= post_f(h0.opm[7],
                                  x_f(h0.opm[1:0], exp_m, exp_p, h0.d, h1.a, exp_bc),
                                  z_f(h0.opm[3:2], cur_s.pcin, exp_p, h0.c),
                                  exp_cin);
      h0 <= cur_s;
      h1 <= h0;
    end
  end

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("model_M",         48'(M),         48'(exp_m));
      chk("model_P",         P,              exp_p);
      chk("model_PCOUT",     PCOUT,          exp_p);
      chk("model_BCOUT",     48'(BCOUT),     48'(exp_bc));
      chk("model_CARRYOUT",  48'(CARRYOUT),  48'(exp_co));
      chk("model_CARRYOUTF", 48'(CARRYOUTF), 48'(exp_co));
    end
  end

  // Inputs change 3 time units after a rising edge.
  task automatic wait_edges(input int n);
    repeat (n) @(posedge CLK);
    #3;
  endtask

  initial begin
    rst = 1'b1; cep = 1'b1;
    A = '0; B = '0; D = '0; BCIN = 18'd7; C = '0; PCIN = '0; CARRYIN = 1'b0; OPMODE = '0;
    wait_edges(2);
    rst = 1'b0;
    chk_en = 1'b1;

    // Pre-add MAC: (25+10)*20 + 350
    OPMODE = 8'h1D; A = 18'd20; B = 18'd10; D = 18'd25; C = 48'd350;
    wait_edges(4);
    chk("mac_M", 48'(M), 48'd700);
    chk("mac_P", P, 48'd1050);

    // Mid-run reset clears immediately and holds
    rst = 1'b1;
    #1;
    chk("rst_P", P, 48'd0);
    chk("rst_M", 48'(M), 48'd0);
    chk("rst_BCOUT", 48'(BCOUT), 48'd0);
    chk("rst_CO", 48'(CARRYOUT), 48'd0);
    wait_edges(2);
    chk("rst_hold_P", P, 48'd0);
    chk("rst_hold_M", 48'(M), 48'd0);
    rst = 1'b0;

    // Pre-subtract, post-subtract: 350 - (25-10)*20
    OPMODE = 8'hDD;
    wait_edges(5);
    chk("sub_M", 48'(M), 48'd300);
    chk("sub_P", P, 48'd50);
    chk("sub_CO", 48'(CARRYOUT), 48'd0);

    // Concatenation path
    OPMODE = 8'h03; D = 18'h30ABC; A = 18'd1; B = 18'd2;
    wait_edges(4);
    chk("cat_P", P, 48'hABC000040002);

    // PCIN pass-through
    OPMODE = 8'h04; PCIN = 48'h123456789ABC;
    wait_edges(3);
    chk("pcin_P", P, 48'h123456789ABC);

    // Accumulate 3*4 + carry from a clean start
    rst = 1'b1;
    wait_edges(1);
    rst = 1'b0;
    OPMODE = 8'h29; A = 18'd3; B = 18'd4; D = '0; C = '0; PCIN = '0;
    wait_edges(4);
    chk("acc_P0", P, 48'd14);
    wait_edges(1);
    chk("acc_P1", P, 48'd27);
    wait_edges(1);
    chk("acc_P2", P, 48'd40);
    cep = 1'b0;
    wait_edges(2);
    chk("frz_P", P, 48'd40);

    // All-ones C plus carry wraps to zero with carry out
    cep = 1'b1;
    OPMODE = 8'h2C; C = 48'hFFFFFFFFFFFF; A = '0; B = '0;
    wait_edges(4);
    chk("cy_P", P, 48'd0);
    chk("cy_CO", 48'(CARRYOUT), 48'd1);
    chk("cy_COF", 48'(CARRYOUTF), 48'd1);

    // Cascade B input on the second slice
    OPMODE = 8'h01; A = 18'd2; C = '0;
    wait_edges(4);
    chk("cas_BCOUT", 48'(k_BCOUT), 48'd7);
    chk("cas_P", k_P, 48'd14);
    chk("cas_M", 48'(k_M), 48'd14);
    chk("dir_P", P, 48'd0);

    chk_en = 1'b0;
    @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
